vga_sync_gen: RTL and testbench

- Timing generator directly upstream of screen_interface2.
- Produces hsync/vsync for the monitor.
- Produces active-area pixel coordinates c1 (column) and c2 (row) plus a ready qualifier; these drive screen_interface2's c1/c2 inputs and frame the vga_control_2 RAM fetch.
- Default timing is 800x600@72 Hz at a 50 MHz clock (one pixel per clk).

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 37 +++
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 800x600@72 Hz at 50 MHz, one pixel per clk.
// Also used by screen_interface2 for the c1/c2 coordinate width.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 11;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 56;
    localparam int unsigned DEF_H_SYNC   = 120;
    localparam int unsigned DEF_H_BP     = 64;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 37;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BP     = 23;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic bit fits_coord(input int unsigned total);
        return total <= (1 << COORD_W);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 on tick and decodes the active and sync regions.
// Region order is active, front porch, sync, back porch.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               tick,
    output logic [COORD_W-1:0] cnt,
    output logic               in_active,
    output logic               in_sync,
    output logic               wrap
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST       = COORD_W'(TOTAL - 1);
    localparam coord_t SYNC_START = COORD_W'(ACTIVE + FP);
    localparam coord_t SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);

    assign wrap      = tick && (cnt == LAST);
    assign in_active = cnt < COORD_W'(ACTIVE);
    assign in_sync   = (cnt >= SYNC_START) && (cnt < SYNC_END);

    always_ff @(posedge clk) begin
        if (clr || wrap) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + COORD_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: hsync/vsync, active-area coordinates and frame/line markers.
// Optional frame_cnt output when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               ready,
    output logic [COORD_W-1:0] c1,
    output logic [COORD_W-1:0] c2,
    output logic               frame_start,
    output logic               line_end
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t      H_LAST_ACTIVE = COORD_W'(H_ACTIVE - 1);

    if (!fits_coord(H_TOTAL) || !fits_coord(V_TOTAL)) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 2048");
    end

    logic   clr;
    logic   running;
    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_active;
    logic   h_in_sync;
    logic   h_wrap;
    logic   v_active;
    logic   v_in_sync;
    logic   v_wrap_unused;
    logic   in_area;
    logic   at_origin;

    assign clr = rst || !en;

    // running delays counting by one edge so every stream starts at (0,0).
    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .clr       (clr),
        .tick      (running),
        .cnt       (h_cnt),
        .in_active (h_active),
        .in_sync   (h_in_sync),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .clr       (clr),
        .tick      (h_wrap),
        .cnt       (v_cnt),
        .in_active (v_active),
        .in_sync   (v_in_sync),
        .wrap      (v_wrap_unused)
    );

    assign in_area   = h_active && v_active;
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk) begin
        if (clr || !running) begin
            running     <= !clr;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            ready       <= 1'b0;
            c1          <= '0;
            c2          <= '0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else begin
            hsync       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            ready       <= in_area;
            c1          <= in_area ? h_cnt : '0;
            c2          <= in_area ? v_cnt : '0;
            frame_start <= at_origin;
            line_end    <= (h_cnt == H_LAST_ACTIVE) && v_active;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            frame_cnt <= '0;
        end else if (running && at_origin) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shrunken timing so many frames fit in the run.
module tb_vga_sync_gen;

    localparam int HA = 10, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic POL = 1'b1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        rdy;
        logic [10:0] c1;
        logic [10:0] c2;
        logic        fs;
        logic        le;
        logic [7:0]  fc;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        hsync, vsync, ready, frame_start, line_end;
    logic [10:0] c1, c2;
    logic [7:0]  frame_cnt_obs;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0]  frame_cnt;
    assign frame_cnt_obs = frame_cnt;
`else
    assign frame_cnt_obs = 8'd0;
`endif

    out_t exp_q[$];
    int   s = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    vga_sync_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (POL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .ready       (ready),
        .c1          (c1),
        .c2          (c2),
        .frame_start (frame_start),
        .line_end    (line_end)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // s = edges seen since the stream was (re)started; pixel stream begins at s = 2.
    function automatic out_t model(input int sv);
        out_t o;
        int   p, h, v;
        o = '0;
        o.hs = ~POL;
        o.vs = ~POL;
        if (sv >= 2) begin
            p = (sv - 2) % FRAME;
            h = p % HT;
            v = p / HT;
            o.rdy = (h < HA) && (v < VA);
            o.c1  = o.rdy ? 11'(h) : 11'd0;
            o.c2  = o.rdy ? 11'(v) : 11'd0;
            o.hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
            o.vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
            o.fs  = (p == 0);
            o.le  = (h == HA - 1) && (v < VA);
`ifdef VGA_SYNC_FRAME_CNT_EN
            o.fc  = 8'(((sv - 2) / FRAME + 1) % 256);
`endif
        end
        return o;
    endfunction

    function automatic bit model_vsync(input int sv);
        out_t o;
        o = model(sv);
        return o.vs == POL;
    endfunction

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
        if (r || !e) s = 0;
        else         s = s + 1;
        exp_q.push_back(model(s));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    // Monitor: every output edge is a transaction; pop expected and compare.
    initial begin
        out_t a, e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a.hs = hsync; a.vs = vsync; a.rdy = ready;
                a.c1 = c1; a.c2 = c2; a.fs = frame_start; a.le = line_end;
                a.fc = frame_cnt_obs;
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @cycle %0d: got hs=%b vs=%b rdy=%b c1=%0d c2=%0d fs=%b le=%b fc=%0d, expected hs=%b vs=%b rdy=%b c1=%0d c2=%0d fs=%b le=%b fc=%0d",
                             cyc, a.hs, a.vs, a.rdy, a.c1, a.c2, a.fs, a.le, a.fc,
                             e.hs, e.vs, e.rdy, e.c1, e.c2, e.fs, e.le, e.fc);
                end
            end
        end
    end

    initial begin
        int tries;
        // reset, then release with en high: frame_start on 2nd edge after release
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        run(3 * FRAME + 7);

        // drop en mid-frame at the middle of the active area
        tries = 0;
        while (!(s >= 2 && ((s - 2) % FRAME) == (VA / 2) * HT + HA / 2) && tries < 2 * FRAME) begin
            step(1'b0, 1'b1);
            tries++;
        end
        n_cmp++;
        if (tries >= 2 * FRAME) begin
            n_bad++;
            $display("FAIL en_drop_seek: got timeout after %0d cycles, expected mid-frame position", tries);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        run(FRAME + 20);

        // one-clk reset during vsync
        tries = 0;
        while (!model_vsync(s) && tries < 2 * FRAME) begin
            step(1'b0, 1'b1);
            tries++;
        end
        n_cmp++;
        if (tries >= 2 * FRAME) begin
            n_bad++;
            $display("FAIL vsync_seek: got timeout after %0d cycles, expected vsync region", tries);
        end
        run(3);
        step(1'b1, 1'b1);
        run(FRAME + 5);

        // random en drops and reset pulses
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0));
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) step(1'b0, 1'b0);
            run($urandom_range(2, 2 * FRAME));
        end

        // long run: 257 frames exercises frame_cnt wrap, then a single en=0 clear
        step(1'b0, 1'b0);
        run(257 * FRAME + 10);
        step(1'b0, 1'b0);
        run(FRAME + 3);

        @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
